// File: rtl/pixel_word_writer.sv
// Packs the downscaler's 8-bit pixel stream into little-endian 32-bit words,
// queues them in a small FIFO and drains them over a req/ack memory write port.
module pixel_word_writer #(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_num_pixels,
    input  logic [7:0]        i_pixel,
    input  logic              i_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_be,
    output logic              o_mem_we,
    input  logic              i_mem_ack,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow
);

    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam int              ENTRY_W   = ADDR_W + 36;
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Byte enables for a word whose highest filled lane is 'lane'.
    function automatic logic [3:0] be_for_lane(input logic [1:0] lane);
        case (lane)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            2'd2:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    state_t               state_r, state_next_s;
    logic [ADDR_W-1:0]    waddr_r;
    logic [ADDR_W-1:0]    num_r;
    logic [ADDR_W-1:0]    pix_cnt_r;
    logic [1:0]           lane_r;
    logic [31:0]          pack_r;

    logic [ENTRY_W-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r, rd_ptr_next_s;
    logic [PTR_W:0]       cnt_r, cnt_next_s, cnt_after_pop_s;

    logic [ADDR_W-1:0]    mem_addr_r;
    logic [31:0]          mem_wdata_r;
    logic [3:0]           mem_be_r;
    logic                 mem_we_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 overflow_r;

    logic                 start_s;
    logic                 accept_px_s;
    logic [ADDR_W-1:0]    pix_cnt_inc_s;
    logic                 last_px_s;
    logic                 word_done_s;
    logic [31:0]          lane_data_s;
    logic                 full_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 drop_s;
    logic [ENTRY_W-1:0]   entry_s;
    logic [ENTRY_W-1:0]   head_next_s;

    assign o_mem_addr  = mem_addr_r;
    assign o_mem_wdata = mem_wdata_r;
    assign o_mem_be    = mem_be_r;
    assign o_mem_we    = mem_we_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_overflow  = overflow_r;

    // Packing, FIFO bookkeeping and head-of-queue selection.
    always_comb begin
        start_s         = (state_r == IDLE) && i_start;
        accept_px_s     = (state_r == RUN) && i_valid;
        pix_cnt_inc_s   = pix_cnt_r + ADDR_W'(1);
        last_px_s       = accept_px_s && (pix_cnt_inc_s == num_r);
        word_done_s     = accept_px_s && ((lane_r == 2'd3) || last_px_s);
        lane_data_s     = pack_r | ({24'd0, i_pixel} << {lane_r, 3'b000});
        entry_s         = {waddr_r, lane_data_s, be_for_lane(lane_r)};
        full_s          = (cnt_r == DEPTH_CNT);
        pop_s           = mem_we_r && i_mem_ack;
        // A full FIFO still accepts a word when the head leaves on the same edge.
        push_s          = word_done_s && (!full_s || pop_s);
        drop_s          = word_done_s && full_s && !pop_s;
        rd_ptr_next_s   = rd_ptr_r;
        cnt_after_pop_s = cnt_r;
        if (pop_s) begin
            rd_ptr_next_s   = rd_ptr_r + PTR_W'(1);
            cnt_after_pop_s = cnt_r - (PTR_W + 1)'(1);
        end else begin
            rd_ptr_next_s   = rd_ptr_r;
            cnt_after_pop_s = cnt_r;
        end
        if (push_s) begin
            cnt_next_s = cnt_after_pop_s + (PTR_W + 1)'(1);
        end else begin
            cnt_next_s = cnt_after_pop_s;
        end
        // When the queue drains to empty the pushed word becomes the head directly.
        head_next_s = {mem_addr_r, mem_wdata_r, mem_be_r};
        if (cnt_next_s == (PTR_W + 1)'(0)) begin
            head_next_s = {mem_addr_r, mem_wdata_r, mem_be_r};
        end else if (push_s && (cnt_after_pop_s == (PTR_W + 1)'(0))) begin
            head_next_s = entry_s;
        end else begin
            head_next_s = fifo_mem_r[rd_ptr_next_s];
        end
    end

    // Frame sequencing.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    if (i_num_pixels == {ADDR_W{1'b0}}) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_px_s) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = RUN;
                end
            end
            FLUSH: begin
                if (cnt_next_s == (PTR_W + 1)'(0)) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = FLUSH;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN) || (state_next_s == FLUSH);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Pixel packing, word address and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_r    <= {ADDR_W{1'b0}};
            num_r      <= {ADDR_W{1'b0}};
            pix_cnt_r  <= {ADDR_W{1'b0}};
            lane_r     <= 2'd0;
            pack_r     <= 32'd0;
            overflow_r <= 1'b0;
        end else if (start_s) begin
            waddr_r    <= i_base_addr;
            num_r      <= i_num_pixels;
            pix_cnt_r  <= {ADDR_W{1'b0}};
            lane_r     <= 2'd0;
            pack_r     <= 32'd0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_px_s) begin
                pix_cnt_r <= pix_cnt_inc_s;
                if (word_done_s) begin
                    // Dropped words still advance the address.
                    waddr_r <= waddr_r + ADDR_W'(1);
                    lane_r  <= 2'd0;
                    pack_r  <= 32'd0;
                end else begin
                    lane_r  <= lane_r + 2'd1;
                    pack_r  <= lane_data_s;
                end
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // FIFO pointers and registered write-port head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            cnt_r       <= {(PTR_W + 1){1'b0}};
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'd0;
            mem_be_r    <= 4'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r <= rd_ptr_next_s;
            cnt_r    <= cnt_next_s;
            mem_we_r <= (cnt_next_s != (PTR_W + 1)'(0));
            {mem_addr_r, mem_wdata_r, mem_be_r} <= head_next_s;
        end
    end

    // FIFO storage; contents are meaningless outside the pointer window.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= entry_s;
        end
    end

endmodule

// File: tb/tb_pixel_word_writer.sv
// Directed self-checking bench for pixel_word_writer: packing, partial tails,
// overflow under a stalled port, ack handshakes, zero-length frames and reset abort.
module tb_pixel_word_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [15:0] i_base_addr;
    logic [15:0] i_num_pixels;
    logic [7:0]  i_pixel;
    logic        i_valid;
    logic [15:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        o_mem_we;
    logic        i_mem_ack;
    logic        o_busy;
    logic        o_done;
    logic        o_overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_ack_cyc = 0;
    int ack_mode = 0;
    int ack_ph = 0;

    logic [15:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  wb_q[$];

    logic        prev_pend = 1'b0;
    logic [15:0] prev_a;
    logic [31:0] prev_d;
    logic [3:0]  prev_b;

    pixel_word_writer #(.ADDR_W(16), .FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_num_pixels (i_num_pixels),
        .i_pixel      (i_pixel),
        .i_valid      (i_valid),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_be     (o_mem_be),
        .o_mem_we     (o_mem_we),
        .i_mem_ack    (i_mem_ack),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overflow   (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_write(input int idx, input logic [15:0] ea, input logic [31:0] ed,
                               input logic [3:0] eb);
        if (idx < wa_q.size()) begin
            check_eq($sformatf("wr%0d_addr", idx), 64'(wa_q[idx]), 64'(ea));
            check_eq($sformatf("wr%0d_data", idx), 64'(wd_q[idx]), 64'(ed));
            check_eq($sformatf("wr%0d_be", idx), 64'(wb_q[idx]), 64'(eb));
        end else begin
            check_eq($sformatf("wr%0d_present", idx), 64'(wa_q.size() > idx), 64'd1);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wb_q.delete();
        done_cnt = 0;
    endtask

    task automatic start_frame(input logic [15:0] base, input logic [15:0] num);
        @(posedge clk); #1;
        i_start      = 1'b1;
        i_base_addr  = base;
        i_num_pixels = num;
        @(posedge clk); #1;
        i_start      = 1'b0;
    endtask

    task automatic send_px(input logic [7:0] v);
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_pixel = v;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_pixel = 8'd0;
    endtask

    task automatic wait_done(input int max_cycles);
        for (int k = 0; k < max_cycles && done_cnt == 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_eq("done_once", 64'(done_cnt), 64'd1);
        check_eq("busy_after_done", 64'(o_busy), 64'd0);
    endtask

    // Memory-side acknowledge generator.
    initial begin
        i_mem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            ack_ph++;
            case (ack_mode)
                0:       i_mem_ack = 1'b1;
                1:       i_mem_ack = 1'b0;
                default: i_mem_ack = (ack_ph % 3 == 0);
            endcase
        end
    end

    // Write-port monitor: logs accepted writes, done pulses, and head stability while waiting.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_pend && o_mem_we) begin
                check_eq("hold_addr", 64'(o_mem_addr), 64'(prev_a));
                check_eq("hold_data", 64'(o_mem_wdata), 64'(prev_d));
                check_eq("hold_be", 64'(o_mem_be), 64'(prev_b));
            end
            if (o_mem_we && i_mem_ack) begin
                wa_q.push_back(o_mem_addr);
                wd_q.push_back(o_mem_wdata);
                wb_q.push_back(o_mem_be);
                last_ack_cyc = cyc;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_pend = o_mem_we && !i_mem_ack;
            prev_a    = o_mem_addr;
            prev_d    = o_mem_wdata;
            prev_b    = o_mem_be;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_base_addr  = 16'd0;
        i_num_pixels = 16'd0;
        i_pixel      = 8'd0;
        i_valid      = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_we", 64'(o_mem_we), 64'd0);
        check_eq("rst_busy", 64'(o_busy), 64'd0);
        check_eq("rst_done", 64'(o_done), 64'd0);
        check_eq("rst_ovf", 64'(o_overflow), 64'd0);
        check_eq("rst_addr", 64'(o_mem_addr), 64'd0);
        check_eq("rst_data", 64'(o_mem_wdata), 64'd0);
        check_eq("rst_be", 64'(o_mem_be), 64'd0);
        rst_n = 1'b1;

        // Full words
        ack_mode = 0;
        clear_log();
        start_frame(16'h0100, 16'd8);
        check_eq("t1_busy", 64'(o_busy), 64'd1);
        for (int i = 1; i <= 8; i++) send_px(8'(i));
        idle_cycle();
        wait_done(40);
        check_eq("t1_nwr", 64'(wa_q.size()), 64'd2);
        check_write(0, 16'h0100, 32'h04030201, 4'b1111);
        check_write(1, 16'h0101, 32'h08070605, 4'b1111);
        check_eq("t1_done_lat", 64'(done_cyc - last_ack_cyc), 64'd1);

        // Partial tail with gaps in valid
        clear_log();
        start_frame(16'h0040, 16'd6);
        send_px(8'hA0); idle_cycle();
        send_px(8'hA1); send_px(8'hA2); idle_cycle(); idle_cycle();
        send_px(8'hA3); send_px(8'hA4); idle_cycle();
        send_px(8'hA5); idle_cycle();
        wait_done(40);
        check_eq("t2_nwr", 64'(wa_q.size()), 64'd2);
        check_write(0, 16'h0040, 32'hA3A2A1A0, 4'b1111);
        check_write(1, 16'h0041, 32'h0000A5A4, 4'b0011);

        // Stalled memory: ninth word dropped, tenth lands at base+9
        ack_mode = 1;
        clear_log();
        start_frame(16'h0300, 16'd40);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 33) check_eq("t3_ovf_before", 64'(o_overflow), 64'd0);
            if (i == 37) begin
                check_eq("t3_ovf_set", 64'(o_overflow), 64'd1);
                ack_mode = 0;
            end
            i_valid = 1'b1;
            i_pixel = 8'(i);
        end
        idle_cycle();
        wait_done(60);
        check_eq("t3_ovf_sticky", 64'(o_overflow), 64'd1);
        check_eq("t3_nwr", 64'(wa_q.size()), 64'd9);
        for (int k = 0; k < 8; k++) begin
            check_write(k, 16'h0300 + 16'(k),
                        {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)}, 4'b1111);
        end
        check_write(8, 16'h0309, {8'd40, 8'd39, 8'd38, 8'd37}, 4'b1111);

        // Zero-length frame; valid in IDLE ignored
        clear_log();
        send_px(8'hEE); send_px(8'hEF); send_px(8'hF0); idle_cycle();
        start_frame(16'h0123, 16'd0);
        check_eq("t4_ovf_clr", 64'(o_overflow), 64'd0);
        repeat (4) @(negedge clk);
        check_eq("t4_done_once", 64'(done_cnt), 64'd1);
        check_eq("t4_nwr", 64'(wa_q.size()), 64'd0);
        check_eq("t4_busy", 64'(o_busy), 64'd0);

        // Start while busy ignored
        clear_log();
        start_frame(16'h0500, 16'd4);
        send_px(8'h31);
        i_start      = 1'b1;
        i_base_addr  = 16'h0777;
        i_num_pixels = 16'd2;
        send_px(8'h32);
        i_start = 1'b0;
        send_px(8'h33); send_px(8'h34); idle_cycle();
        wait_done(40);
        check_eq("t4b_nwr", 64'(wa_q.size()), 64'd1);
        check_write(0, 16'h0500, 32'h34333231, 4'b1111);

        // Ack every third cycle
        ack_mode = 2;
        clear_log();
        start_frame(16'h0600, 16'd12);
        for (int i = 0; i < 12; i++) send_px(8'h50 + 8'(i));
        idle_cycle();
        wait_done(80);
        check_eq("t5_nwr", 64'(wa_q.size()), 64'd3);
        check_write(0, 16'h0600, 32'h53525150, 4'b1111);
        check_write(1, 16'h0601, 32'h57565554, 4'b1111);
        check_write(2, 16'h0602, 32'h5B5A5958, 4'b1111);

        // Reset mid-frame with two words queued
        ack_mode = 1;
        clear_log();
        start_frame(16'h0700, 16'd16);
        for (int i = 0; i < 8; i++) send_px(8'h60 + 8'(i));
        idle_cycle();
        @(negedge clk);
        check_eq("t6_we_pre", 64'(o_mem_we), 64'd1);
        check_eq("t6_busy_pre", 64'(o_busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_we_rst", 64'(o_mem_we), 64'd0);
        check_eq("t6_busy_rst", 64'(o_busy), 64'd0);
        check_eq("t6_ovf_rst", 64'(o_overflow), 64'd0);
        repeat (2) @(negedge clk);
        check_eq("t6_no_done", 64'(done_cnt), 64'd0);
        rst_n    = 1'b1;
        ack_mode = 0;
        clear_log();
        start_frame(16'h0200, 16'd4);
        for (int i = 0; i < 4; i++) send_px(8'h11 + 8'(i));
        idle_cycle();
        wait_done(40);
        check_eq("t6_nwr", 64'(wa_q.size()), 64'd1);
        check_write(0, 16'h0200, 32'h14131211, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pixel_word_writer.md
Name: pixel_word_writer

Overview:
- Sink for the downscaler pipeline's final output stream: 8-bit unsigned pixel plus valid strobe, one pixel per cycle max, no backpressure.
- Packs pixels little-endian into 32-bit words and buffers them in a small FIFO.
- Drains words to output memory over a req/ack write port, starting from a programmable base word address.
- Tracks the per-frame pixel count, flushes the final partial word with byte enables, and signals frame completion.

Parameters:
ADDR_W, 16, width of word address and pixel-count fields
FIFO_DEPTH, 8, number of buffered packed words (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  start-of-frame pulse; sampled only in IDLE
i_base_addr  in  ADDR_W  first word address of frame; latched on accepted i_start
i_num_pixels  in  ADDR_W  pixels in frame; latched on accepted i_start
i_pixel  in  8  output pixel from pipeline
i_valid  in  1  i_pixel valid this cycle
o_mem_addr  out  ADDR_W  word address of current write
o_mem_wdata  out  32  packed word; byte lane k = k-th pixel of word
o_mem_be  out  4  byte enables
o_mem_we  out  1  write request
i_mem_ack  in  1  write accepted this cycle
o_busy  out  1  high in RUN and FLUSH
o_done  out  1  one-cycle end-of-frame pulse
o_overflow  out  1  sticky: a packed word was dropped because the FIFO was full

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. FIFO empty; pack register, lane counter and pixel counter cleared.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - i_valid is ignored.
  - i_start latches base and count, clears counters and o_overflow.
  - Next state is RUN, or DONE if i_num_pixels==0.
- RUN:
  - Each cycle with i_valid, the pixel goes to byte lane = lane counter (0..3); lane counter and pixel counter increment.
  - Word completes when lane 3 is filled, or when the pixel counter reaches i_num_pixels.
  - On completion: push {addr, data, be} into the FIFO at that clock edge; be = 4'b1111 for a full word, else low lanes only (1 px→0001, 2→0011, 3→0111).
  - Word address increments by 1 per completed word, including dropped words, so later pixels still land at the correct addresses.
  - Unused lanes of a partial word are 0.
  - After the last pixel is pushed, go to FLUSH. i_valid during FLUSH is ignored.
- Overflow: if the FIFO is full at push time and no pop occurs that same cycle, the word is dropped and o_overflow is set (sticky until the next accepted start). A simultaneous pop and push on a full FIFO succeeds.
- Write port:
  - o_mem_we = FIFO not empty. addr/wdata/be come from the FIFO head.
  - Head is held stable until a cycle with o_mem_we && i_mem_ack; pop occurs on that edge.
  - o_mem_we may remain high back-to-back: one word per cycle at sustained ack.
  - i_mem_ack with o_mem_we low is ignored.
- Latency: a word pushed at edge N has o_mem_we high from cycle N+1 when the FIFO was empty.
- FLUSH → DONE when the FIFO is empty (last ack consumed).
- DONE: o_done=1 for exactly one cycle, then IDLE. o_busy=0 in IDLE and DONE.
- i_start outside IDLE is ignored.
- Counters: the pixel counter is ADDR_W bits. Word address wraps modulo 2^ADDR_W without error.
- Reset mid-frame: immediate abort. FIFO contents discarded, o_mem_we drops asynchronously to 0, no o_done.

Test Plan:
- Full words: base=0x0100, num=8, pixels 0x01..0x08 on consecutive cycles, ack always 1 → writes (0x0100, 0x04030201, 1111) and (0x0101, 0x08070605, 1111); o_done one cycle after the last ack.
- Partial tail: num=6, pixels 0xA0..0xA5 with gaps in i_valid → second write is addr base+1, data 0x0000A5A4, be 0011.
- Stalled memory: num=40 back-to-back, ack held 0 → 8 words buffered; word 9 dropped with o_overflow=1. After ack is released, writes continue with address base+9 (base+8 skipped), and o_done fires.
- Zero-length and ignored inputs: num=0 → o_done pulses two cycles after start with no writes. i_valid in IDLE and i_start while busy have no effect.
- Ack handshake: ack asserted every third cycle → head addr/data/be stay stable across wait cycles; each word is written exactly once, in order.
- Reset mid-frame: rst_n low during RUN with 2 words queued → o_mem_we, o_busy and o_overflow go to 0 immediately. A following frame with base=0x0200 writes correctly from lane 0.
